// File: rtl/food_lfsr.sv
// Pseudo-random food-cell generator: free-running 16-bit LFSR sampled on each
// synchronised rising edge of the game tick, with Y folded into the 48-row grid.
module food_lfsr #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int unsigned Y_MAX  = 47,
  parameter int unsigned Y_FOLD = 16
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       clk2,
  output logic [5:0] XCoord,
  output logic [5:0] YCoord
);

  localparam int unsigned CoordW = 6;
  localparam int unsigned LfsrW  = 16;

  logic [LfsrW-1:0]  lfsr;
  logic              s1, s2, s3;
  logic              fb;
  logic              tick;
  logic [CoordW-1:0] rawY;
  logic [CoordW-1:0] foldY;

  assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tick  = s2 & ~s3;
  assign rawY  = lfsr[11:6];
  // Rows 48..63 fold back onto 32..47 so every latched row is on the grid.
  assign foldY = (rawY > CoordW'(Y_MAX)) ? (rawY - CoordW'(Y_FOLD)) : rawY;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      lfsr   <= SEED;
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      XCoord <= '0;
      YCoord <= '0;
    end else begin
      // An all-zero register would lock up, so reseed instead of shifting.
      lfsr <= (lfsr == '0) ? SEED : {lfsr[LfsrW-2:0], fb};
      s1   <= clk2;
      s2   <= s1;
      s3   <= s2;
      if (tick) begin
        XCoord <= lfsr[5:0];
        YCoord <= foldY;
      end
    end
  end

endmodule

// File: tb/tb_food_lfsr.sv
// Directed self-checking bench for food_lfsr against a reference LFSR model.
module tb_food_lfsr;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       clk2;
  logic [5:0] XCoord, YCoord;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [15:0] mL;
  logic [5:0]  lastX, lastY;
  bit          seen0, seen63;

  food_lfsr #(.SEED(SEED), .Y_MAX(47), .Y_FOLD(16)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .clk2  (clk2),
    .XCoord(XCoord),
    .YCoord(YCoord)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [15:0] stepL(input logic [15:0] l);
    if (l == 16'h0) return SEED;
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [5:0] foldRow(input logic [5:0] y);
    return (y > 6'd47) ? y - 6'd16 : y;
  endfunction

  // Reference register, advanced on the same edges as the DUT.
  always @(posedge clk1) begin
    if (!rst_n) mL <= SEED;
    else        mL <= stepL(mL);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // clk2 high for hi cycles then low for lo cycles (hi >= 3), checking latency and hold.
  task automatic doPulse(input int hi, input int lo);
    logic [5:0] oX, oY, eX, eY;
    oX = XCoord;
    oY = YCoord;
    clk2 = 1'b1;
    @(negedge clk1);
    chk("early_x1", 16'(XCoord), 16'(oX));
    @(negedge clk1);
    chk("early_x2", 16'(XCoord), 16'(oX));
    chk("early_y2", 16'(YCoord), 16'(oY));
    eX = mL[5:0];
    eY = foldRow(mL[11:6]);
    @(negedge clk1);
    chk("tick_x", 16'(XCoord), 16'(eX));
    chk("tick_y", 16'(YCoord), 16'(eY));
    chk("y_range", 16'(YCoord <= 6'd47), 16'd1);
    for (int i = 3; i < hi; i++) begin
      @(negedge clk1);
      chk("hold_hi", {4'h0, XCoord, YCoord}, {4'h0, eX, eY});
    end
    clk2 = 1'b0;
    for (int i = 0; i < lo; i++) begin
      @(negedge clk1);
      chk("hold_lo", {4'h0, XCoord, YCoord}, {4'h0, eX, eY});
    end
    lastX = eX;
    lastY = eY;
  endtask

  // Times a pulse so the latched raw row equals target, then checks the folded row.
  task automatic foldHit(input logic [5:0] target, input logic [5:0] expY, input string tag);
    logic [15:0] ahead;
    bit found;
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clk1);
      ahead = stepL(stepL(mL));
      if (ahead[11:6] == target) found = 1'b1;
    end
    if (found) begin
      doPulse(4, 4);
      chk(tag, 16'(YCoord), 16'(expY));
    end else begin
      chk({tag, "_timeout"}, 16'd0, 16'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clk2  = 1'b0;
    repeat (3) @(negedge clk1);
    chk("rst_x", 16'(XCoord), 16'd0);
    chk("rst_y", 16'(YCoord), 16'd0);
    chk("rst_lfsr", dut.lfsr, SEED);
    rst_n = 1'b1;
    @(negedge clk1);
    chk("first_step", dut.lfsr, 16'h59C3);
    chk("model_sync", dut.lfsr, mL);

    repeat (5) @(negedge clk1);
    chk("idle_x", 16'(XCoord), 16'd0);
    chk("idle_y", 16'(YCoord), 16'd0);

    doPulse(4, 4);

    foldHit(6'd50, 6'd34, "fold_50");
    foldHit(6'd47, 6'd47, "fold_47");
    foldHit(6'd63, 6'd47, "fold_63");
    foldHit(6'd48, 6'd32, "fold_48");

    seen0  = 1'b0;
    seen63 = 1'b0;
    for (int p = 0; p < 1000; p++) begin
      doPulse(10, 10);
      if (lastX == 6'd0)  seen0  = 1'b1;
      if (lastX == 6'd63) seen63 = 1'b1;
    end
    chk("seen_x0", 16'(seen0), 16'd1);
    chk("seen_x63", 16'(seen63), 16'd1);
    chk("model_sync2", dut.lfsr, mL);

    // Reset lands on the edge where the tick would latch.
    chk("pre_rst_nonzero", 16'({XCoord, YCoord} != 12'h0), 16'd1);
    clk2 = 1'b1;
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b0;
    clk2  = 1'b0;
    @(negedge clk1);
    chk("midrst_x", 16'(XCoord), 16'd0);
    chk("midrst_y", 16'(YCoord), 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      chk("midrst_hold", {4'h0, XCoord, YCoord}, 16'h0);
    end
    doPulse(4, 4);

    @(negedge clk1);
    force dut.lfsr = 16'h0;
    #1 release dut.lfsr;
    chk("forced_zero", dut.lfsr, 16'h0);
    @(negedge clk1);
    chk("lockup_reseed", dut.lfsr, SEED);
    @(negedge clk1);
    chk("lockup_step", dut.lfsr, 16'h59C3);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
